// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

    // Execute-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 is hard-wired and never participates in dependencies
    localparam int unsigned REG_ZERO = 0;

    // Counter width of the multi-cycle sequencer
    localparam int unsigned MUL_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/hazard_controller_mul_sequencer.sv
// Holds a multi-cycle Execute op in E for MUL_LAT cycles.
module mul_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic mstall_c,
    output logic busy_c,
    output logic done_c
);

    localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(MUL_LAT - 2);

    mul_state_e             state_q, state_d;
    logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;

    // State and countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and stall/done decode; start is ignored outside IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mstall_c = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mstall_c = 1'b1;
                    if (MUL_LAT == 2) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                mstall_c = 1'b1;
                busy_c   = 1'b1;
                if (cnt_q == MUL_CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - MUL_CNT_W'(1);
                end
            end
            DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding, hazard detection, stall/flush generation and perf counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned AWL     = 6,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned PERF_WL = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [AWL-2:0]     RsD,
    input  logic [AWL-2:0]     RtD,
    input  logic [AWL-2:0]     RsE,
    input  logic [AWL-2:0]     RtE,
    input  logic [AWL-2:0]     RFAE,
    input  logic [AWL-2:0]     RFAM,
    input  logic [AWL-2:0]     RFAW,
    input  logic               RFWEE,
    input  logic               RFWEM,
    input  logic               RFWEW,
    input  logic               MtoRFSelE,
    input  logic               MtoRFSelM,
    input  logic               BranchD,
    input  logic               PCSrcD,
    input  logic               MulStartE,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               ForwardAD,
    output logic               ForwardBD,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushM,
    output logic               MulBusy,
    output logic               MulDone,
    output logic [PERF_WL-1:0] StallCnt,
    output logic [PERF_WL-1:0] FlushCnt
);

    localparam int unsigned RW = AWL - 1;

    logic mstall_c, busy_c, done_c;
    logic lwstall_c, brstall_c, stall_c;

    function automatic logic hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != RW'(REG_ZERO)) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                           input logic [RW-1:0] dst_m, input logic we_m,
                                           input logic [RW-1:0] dst_w, input logic we_w);
        if (we_m && hit(src, dst_m))      return FWD_MEM;
        else if (we_w && hit(src, dst_w)) return FWD_WB;
        else                              return FWD_RF;
    endfunction

    mul_sequencer #(.MUL_LAT(MUL_LAT)) u_mul_seq (
        .clk      (CLK),
        .rst      (RST),
        .start    (MulStartE),
        .mstall_c (mstall_c),
        .busy_c   (busy_c),
        .done_c   (done_c)
    );

    // Hazard detection and pipeline controls; everything reads 0 during reset
    always_comb begin
        lwstall_c = MtoRFSelE & RFWEE & (hit(RFAE, RsD) | hit(RFAE, RtD));
        brstall_c = BranchD & ((RFWEE & (hit(RFAE, RsD) | hit(RFAE, RtD))) |
                               (MtoRFSelM & (hit(RFAM, RsD) | hit(RFAM, RtD))));
        stall_c   = ~RST & (lwstall_c | brstall_c | mstall_c);

        ForwardAE = RST ? FWD_RF : fwd_sel(RsE, RFAM, RFWEM, RFAW, RFWEW);
        ForwardBE = RST ? FWD_RF : fwd_sel(RtE, RFAM, RFWEM, RFAW, RFWEW);
        ForwardAD = ~RST & RFWEM & hit(RsD, RFAM);
        ForwardBD = ~RST & RFWEM & hit(RtD, RFAM);

        StallF  = stall_c;
        StallD  = stall_c;
        StallE  = ~RST & mstall_c;
        FlushM  = ~RST & mstall_c;
        FlushE  = ~RST & (lwstall_c | brstall_c) & ~mstall_c;
        FlushD  = ~RST & PCSrcD & ~stall_c;
        MulBusy = ~RST & busy_c;
        MulDone = ~RST & done_c;
    end

    // Saturating stall/flush cycle counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && (StallCnt != '1))
                StallCnt <= StallCnt + PERF_WL'(1);
            if ((FlushD || FlushE) && (FlushCnt != '1))
                FlushCnt <= FlushCnt + PERF_WL'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed test-plan steps plus
// random traffic compared against a cycle-level behavioural model.
module tb_hazard_controller;

    localparam int unsigned AWL = 6;
    localparam int unsigned RW  = AWL - 1;
    localparam int unsigned ML  = 4;
    localparam int unsigned PW  = 6;
    localparam int          CMAX = (1 << PW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, rfa_e, rfa_m, rfa_w;
    logic          rfwe_e, rfwe_m, rfwe_w, mtorf_e, mtorf_m;
    logic          branch_d, pcsrc_d, mulstart_e;

    logic [1:0]    fwd_ae, fwd_be;
    logic          fwd_ad, fwd_bd, stall_f, stall_d, stall_e;
    logic          flush_d, flush_e, flush_m, mul_busy, mul_done;
    logic [PW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: cycles since the current multi-cycle op entered E (0 = none)
    int phase  = 0;
    int exp_sc = 0;
    int exp_fc = 0;
    bit e_stall, e_flush;

    hazard_controller #(.AWL(AWL), .MUL_LAT(ML), .PERF_WL(PW)) dut (
        .CLK(CLK), .RST(RST),
        .RsD(rs_d), .RtD(rt_d), .RsE(rs_e), .RtE(rt_e),
        .RFAE(rfa_e), .RFAM(rfa_m), .RFAW(rfa_w),
        .RFWEE(rfwe_e), .RFWEM(rfwe_m), .RFWEW(rfwe_w),
        .MtoRFSelE(mtorf_e), .MtoRFSelM(mtorf_m),
        .BranchD(branch_d), .PCSrcD(pcsrc_d), .MulStartE(mulstart_e),
        .ForwardAE(fwd_ae), .ForwardBE(fwd_be), .ForwardAD(fwd_ad), .ForwardBD(fwd_bd),
        .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
        .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m),
        .MulBusy(mul_busy), .MulDone(mul_done),
        .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic int fwd_exp(input logic [RW-1:0] src);
        if (rfwe_m && dep(src, rfa_m)) return 2;
        if (rfwe_w && dep(src, rfa_w)) return 1;
        return 0;
    endfunction

    // Compare every output against the model for the current inputs
    task automatic check_model();
        bit lw, br, ms, st, fe, fd;
        if (RST) begin
            lw = 0; br = 0; ms = 0;
        end else begin
            lw = mtorf_e && rfwe_e && (dep(rfa_e, rs_d) || dep(rfa_e, rt_d));
            br = branch_d && ((rfwe_e && (dep(rfa_e, rs_d) || dep(rfa_e, rt_d))) ||
                              (mtorf_m && (dep(rfa_m, rs_d) || dep(rfa_m, rt_d))));
            ms = (phase == 0) ? mulstart_e : (phase < ML - 1);
        end
        st = lw || br || ms;
        fe = (lw || br) && !ms;
        fd = !RST && pcsrc_d && !st;
        e_stall = st;
        e_flush = fe || fd;
        chk("fwd_ae",  32'(fwd_ae),  RST ? 0 : fwd_exp(rs_e));
        chk("fwd_be",  32'(fwd_be),  RST ? 0 : fwd_exp(rt_e));
        chk("fwd_ad",  32'(fwd_ad),  32'(!RST && rfwe_m && dep(rs_d, rfa_m)));
        chk("fwd_bd",  32'(fwd_bd),  32'(!RST && rfwe_m && dep(rt_d, rfa_m)));
        chk("stall_f", 32'(stall_f), 32'(st));
        chk("stall_d", 32'(stall_d), 32'(st));
        chk("stall_e", 32'(stall_e), 32'(ms));
        chk("flush_d", 32'(flush_d), 32'(fd));
        chk("flush_e", 32'(flush_e), 32'(fe));
        chk("flush_m", 32'(flush_m), 32'(ms));
        chk("mul_busy", 32'(mul_busy), 32'(!RST && phase != 0));
        chk("mul_done", 32'(mul_done), 32'(!RST && phase == ML - 1));
        chk("stall_cnt", 32'(stall_cnt), RST ? 0 : exp_sc);
        chk("flush_cnt", 32'(flush_cnt), RST ? 0 : exp_fc);
    endtask

    // Check, take one clock edge, advance the model, return at the negedge
    task automatic step();
        #1;
        check_model();
        @(posedge CLK);
        if (RST) begin
            phase = 0; exp_sc = 0; exp_fc = 0;
        end else begin
            if (phase == 0) phase = mulstart_e ? 1 : 0;
            else            phase = (phase == ML - 1) ? 0 : phase + 1;
            if (e_stall && exp_sc < CMAX) exp_sc++;
            if (e_flush && exp_fc < CMAX) exp_fc++;
        end
        @(negedge CLK);
    endtask

    task automatic quiet();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; rfa_e = 0; rfa_m = 0; rfa_w = 0;
        rfwe_e = 0; rfwe_m = 0; rfwe_w = 0; mtorf_e = 0; mtorf_m = 0;
        branch_d = 0; pcsrc_d = 0; mulstart_e = 0;
    endtask

    initial begin
        int sc0;
        // Reset with activity on the inputs: outputs must read 0
        RST = 1'b1;
        quiet();
        mulstart_e = 1; pcsrc_d = 1; rs_e = 5; rfa_m = 5; rfwe_m = 1;
        mtorf_e = 1; rfwe_e = 1; rfa_e = 8; rs_d = 8;
        step();
        RST = 1'b0;
        quiet();
        step();

        // Forwarding priority: M over W, then W, then register 0 never forwards
        rs_e = 5; rt_e = 5; rfa_m = 5; rfwe_m = 1; rfa_w = 5; rfwe_w = 1;
        #1; chk("fwd_mem_a", 32'(fwd_ae), 2); chk("fwd_mem_b", 32'(fwd_be), 2);
        step();
        rfwe_m = 0;
        #1; chk("fwd_wb_a", 32'(fwd_ae), 1);
        step();
        rs_e = 0; rt_e = 0; rfa_m = 0; rfa_w = 0; rfwe_m = 1;
        #1; chk("fwd_r0", 32'(fwd_ae), 0);
        step();

        // Load-use stall for one cycle
        quiet();
        mtorf_e = 1; rfwe_e = 1; rfa_e = 8; rs_d = 8;
        sc0 = exp_sc;
        #1; chk("lw_flush_e", 32'(flush_e), 1); chk("lw_stall_e", 32'(stall_e), 0);
        step();
        quiet();
        chk("lw_cnt", 32'(stall_cnt), 32'(sc0 + 1));
        step();

        // Branch stall suppresses a taken branch, then it flushes D
        branch_d = 1; pcsrc_d = 1; rs_d = 3; rfa_e = 3; rfwe_e = 1;
        #1; chk("br_stall", 32'(stall_d), 1); chk("br_nofl", 32'(flush_d), 0);
        step();
        rfa_e = 0; rfwe_e = 0;
        #1; chk("br_flush", 32'(flush_d), 1);
        step();
        quiet();
        step();

        // Clean multiply: three stall cycles, done on the fourth
        sc0 = exp_sc;
        mulstart_e = 1;
        for (int i = 0; i < ML; i++) begin
            #1; chk("mul_seq_done", 32'(mul_done), 32'(i == ML - 1));
            step();
        end
        mulstart_e = 0;
        chk("mul_cnt", 32'(stall_cnt), 32'(sc0 + ML - 1));
        step();

        // Multiply with load-use at t+1 and back-to-back restart at t+4
        mulstart_e = 1;
        step();
        mtorf_e = 1; rfwe_e = 1; rfa_e = 8; rs_d = 8;
        #1; chk("mul_lw_fe", 32'(flush_e), 0); chk("mul_lw_se", 32'(stall_e), 1);
        step();
        mtorf_e = 0; rfwe_e = 0;
        step(); step();
        #1; chk("b2b_stall", 32'(stall_e), 1);
        step();

        // Reset mid-BUSY abandons the op
        #2; RST = 1'b1;
        #1; chk("rst_busy", 32'(mul_busy), 0); chk("rst_stall", 32'(stall_f), 0);
        step();
        RST = 1'b0; mulstart_e = 0;
        step();
        mulstart_e = 1;
        for (int i = 0; i < ML; i++) step();
        mulstart_e = 0;

        // Saturation of the stall counter
        mtorf_e = 1; rfwe_e = 1; rfa_e = 8; rs_d = 8;
        for (int i = 0; i < CMAX + 8; i++) step();
        chk("sat_stall", 32'(stall_cnt), CMAX);
        quiet();
        step();

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            RST      = ($urandom_range(0, 99) == 0);
            rs_d     = RW'($urandom_range(0, 3)); rt_d  = RW'($urandom_range(0, 3));
            rs_e     = RW'($urandom_range(0, 3)); rt_e  = RW'($urandom_range(0, 3));
            rfa_e    = RW'($urandom_range(0, 3)); rfa_m = RW'($urandom_range(0, 3));
            rfa_w    = RW'($urandom_range(0, 3));
            rfwe_e   = 1'($urandom); rfwe_m = 1'($urandom); rfwe_w = 1'($urandom);
            mtorf_e  = 1'($urandom); mtorf_m = 1'($urandom);
            branch_d = ($urandom_range(0, 2) == 0); pcsrc_d = 1'($urandom);
            mulstart_e = ($urandom_range(0, 5) == 0);
            step();
        end
        RST = 1'b0;
        quiet();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core (F/D/E/M/W).
- Produces the Execute-stage forwarding selects, Decode branch-compare forwarding, and per-stage stall/flush controls.
- Sequences multi-cycle Execute operations (multiply) by holding them in E for MUL_LAT cycles while inserting bubbles into M.
- Keeps saturating stall and flush performance counters.

Parameters:
- AWL, 6, address-width base; register-file address width is AWL-1 (5 bits).
- MUL_LAT, 4, total cycles a multi-cycle op occupies E; legal range 2..16.
- PERF_WL, 16, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RsD, RtD  in  AWL-1  source registers of the instruction in D.
- RsE, RtE  in  AWL-1  source registers of the instruction in E.
- RFAE, RFAM, RFAW  in  AWL-1  destination registers in E, M and W.
- RFWEE, RFWEM, RFWEW  in  1  register-file write enables in E, M and W.
- MtoRFSelE, MtoRFSelM  in  1  load-instruction flags in E and M.
- BranchD  in  1  branch in D.
- PCSrcD  in  1  branch taken in D.
- MulStartE  in  1  multi-cycle op present in E.
- ForwardAE, ForwardBE  out  2  ALU operand A/B select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
- ForwardAD, ForwardBD  out  1  Decode compare operand from ALUOutM.
- StallF, StallD, StallE  out  1  hold the PC, the D register and the E register.
- FlushD, FlushE, FlushM  out  1  clear the D, E and M registers (bubble).
- MulBusy  out  1  multi-cycle sequencer not IDLE.
- MulDone  out  1  last E cycle of a multi-cycle op.
- StallCnt, FlushCnt  out  PERF_WL  performance counters.

Behaviour:

Reset (asynchronous, immediate):
- FSM returns to IDLE; the cycle counter and both perf counters clear to 0.
- All outputs read 0 while RST is high.
- Reset in the middle of a multi-cycle op abandons it with no MulDone.

Register 0:
- Register 0 never matches for forwarding or hazard purposes.

Forwarding (combinational):
- ForwardAE = 10 if RsE≠0 & RsE==RFAM & RFWEM.
- Otherwise ForwardAE = 01 if RsE≠0 & RsE==RFAW & RFWEW.
- Otherwise ForwardAE = 00.
- M takes priority over W.
- ForwardBE follows the same rules using RtE.
- ForwardAD = RsD≠0 & RsD==RFAM & RFWEM; ForwardBD is the same with RtD.

Load-use hazard:
- lwstall = MtoRFSelE & RFWEE & RFAE≠0 & (RFAE==RsD | RFAE==RtD).

Branch hazard:
- brstall = BranchD & ((RFWEE & RFAE≠0 & RFAE∈{RsD,RtD}) | (MtoRFSelM & RFAM≠0 & RFAM∈{RsD,RtD})).

Multi-cycle sequencer FSM (states IDLE, BUSY, DONE; 4-bit counter cnt):
- IDLE with MulStartE: mstall=1. Go to BUSY with cnt=MUL_LAT-2, or directly to DONE if MUL_LAT==2.
- BUSY: mstall=1. If cnt==1 go to DONE, else decrement cnt.
- DONE: mstall=0, MulDone=1, go to IDLE. MulStartE is ignored in DONE because the same op is still visible in E.
- Result: mstall is asserted for exactly MUL_LAT-1 cycles and the op sits in E for MUL_LAT cycles.
- MulBusy=1 in BUSY and DONE.

Control outputs:
- StallF = StallD = lwstall | brstall | mstall.
- StallE = mstall.
- FlushM = mstall.
- FlushE = (lwstall | brstall) & ~mstall. A stall of E overrides its flush.
- FlushD = PCSrcD & ~StallD. A taken branch is ignored while D is stalled, since its operands are not yet valid.
- Back-to-back: MulStartE in the cycle after DONE starts a new sequence normally.

Performance counters (registered):
- StallCnt increments on every cycle with StallF=1.
- FlushCnt increments on every cycle with FlushD|FlushE=1.
- Both saturate at all-ones with no wrap-around.

Decomposition:
- Package hazard_pkg holds:
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding IDLE/BUSY/DONE;
  - register-0 constant.
- One sub-module, mul_sequencer, holds the FSM and cnt and outputs mstall, MulBusy and MulDone.
- Forwarding, hazard detection and the counters stay in the top level.

Test Plan:
- Forwarding priority: RsE=RtE=5, RFAM=5/RFWEM=1, RFAW=5/RFWEW=1 -> ForwardAE=ForwardBE=10. Drop RFWEM -> 01. RsE=0 with all enables set -> 00.
- Load-use: MtoRFSelE=1, RFWEE=1, RFAE=8, RsD=8 -> StallF=StallD=FlushE=1, StallE=0 for one cycle. StallCnt increments by 1.
- Branch: BranchD=1, RsD=3, RFAE=3/RFWEE=1 -> stall with PCSrcD=1 held and FlushD=0. Next cycle with no match -> FlushD=1 and FlushCnt increments.
- Multiply, MUL_LAT=4: MulStartE pulse at cycle t -> StallF/D/E and FlushM high for t..t+2, MulDone=1 at t+3, MulBusy high t+1..t+3, StallCnt increases by 3.
- Multiply concurrent with load-use at t+1 -> FlushE=0, StallE=1 (stall wins). Back-to-back MulStartE at t+4 restarts the sequence.
- RST asserted mid-BUSY -> all outputs 0 immediately and no MulDone. After release, MulStartE starts cleanly. Force StallCnt to all-ones and stall -> it holds at all-ones.
